// File: rtl/psk_ctrl_pkg.sv
// Shared PSK control definitions: sequencer state encodings and MODE_CTRL width/default.
package psk_ctrl_pkg;
  localparam int MODE_W = 4;
  localparam logic [MODE_W-1:0] DEFAULT_MODE = 4'd4;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_RXRST    = 3'd1,
    ST_ACQUIRE  = 3'd2,
    ST_LINKED   = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_RECONFIG = 3'd5
  } state_t;
endpackage

// File: rtl/debounce_2ff.sv
// Two-cycle level qualifier: hi2/lo2 fire once the input has held high/low for two
// consecutive cycles since the last clear.
module debounce_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic hi2,
  output logic lo2
);
  logic seen_hi, seen_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_hi <= 1'b0;
      seen_lo <= 1'b0;
    end else if (clr) begin
      seen_hi <= 1'b0;
      seen_lo <= 1'b0;
    end else begin
      seen_hi <= d;
      seen_lo <= ~d;
    end
  end

  assign hi2 = d & seen_hi;
  assign lo2 = ~d & seen_lo;
endmodule

// File: rtl/psk_link_sequencer.sv
// PSK Tx/Rx link sequencer: boot hold, Rx soft-reset pulse, lock acquisition,
// frame-aligned MODE_CTRL changes and re-acquisition on lock loss or timeout.
module psk_link_sequencer #(
  parameter int         STARTUP_CYCLES = 32768,
  parameter int         RX_RST_CYCLES  = 16,
  parameter int         LOCK_TIMEOUT   = 327680,
  parameter int         DRAIN_TIMEOUT  = 65536,
  parameter logic [3:0] DEFAULT_MODE   = psk_ctrl_pkg::DEFAULT_MODE,
  parameter int         CNT_W          = 20
) (
  input  logic       clk_32M768,
  input  logic       rst_n_32M768,
  input  logic [3:0] mode_req,
  input  logic       mode_req_valid,
  input  logic       tx_frame_last,
  input  logic       dac_tready,
  input  logic       rx_valid,
  output logic [3:0] mode_ctrl,
  output logic       tx_en,
  output logic       rx_rst_n,
  output logic       busy,
  output logic [2:0] state_o,
  output logic [7:0] relock_cnt
);
  import psk_ctrl_pkg::*;

  // Last timer value of each timed state; the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RXRST_LAST = CNT_W'(RX_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic             pend, pend_clr, relock_evt;
  logic [3:0]       pend_mode;
  logic             lock_hi2, lock_lo2, state_chg;

  assign state_chg = (state_nxt != state);
  assign state_o   = state;

  // Qualifier history restarts on every state entry so each state sees fresh evidence.
  debounce_2ff u_lock_qual (
    .clk   (clk_32M768),
    .rst_n (rst_n_32M768),
    .clr   (state_chg),
    .d     (rx_valid),
    .hi2   (lock_hi2),
    .lo2   (lock_lo2)
  );

  always_comb begin
    state_nxt  = state;
    pend_clr   = 1'b0;
    relock_evt = 1'b0;
    case (state)
      ST_BOOT:    if (timer >= BOOT_LAST) state_nxt = ST_RXRST;
      ST_RXRST:   if (timer >= RXRST_LAST) state_nxt = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (lock_hi2) state_nxt = ST_LINKED;
        else if (timer >= LOCK_LAST) begin
          relock_evt = 1'b1;
          state_nxt  = ST_RXRST;
        end
      end
      ST_LINKED: begin
        if (lock_lo2) begin
          relock_evt = 1'b1;
          state_nxt  = ST_RXRST;
        end else if (pend) begin
          if (pend_mode != mode_ctrl) state_nxt = ST_DRAIN;
          else                        pend_clr  = 1'b1;
        end
      end
      ST_DRAIN:    if (tx_frame_last || timer >= DRAIN_LAST) state_nxt = ST_RECONFIG;
      ST_RECONFIG: begin
        pend_clr  = 1'b1;
        state_nxt = ST_RXRST;
      end
      default:     state_nxt = ST_BOOT;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      state      <= ST_BOOT;
      timer      <= '0;
      pend       <= 1'b0;
      pend_mode  <= DEFAULT_MODE;
      mode_ctrl  <= DEFAULT_MODE;
      tx_en      <= 1'b0;
      rx_rst_n   <= 1'b0;
      busy       <= 1'b1;
      relock_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state_chg || state == ST_LINKED) timer <= '0;
      else if (!(&timer))                  timer <= timer + 1'b1;
      // A new request beats a same-cycle clear, so it survives into the next pass.
      if (mode_req_valid) begin
        pend      <= 1'b1;
        pend_mode <= mode_req;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
      if (state == ST_RECONFIG) mode_ctrl <= pend_mode;
      if (relock_evt && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
      tx_en    <= dac_tready && (state_nxt == ST_ACQUIRE || state_nxt == ST_LINKED ||
                                 state_nxt == ST_DRAIN);
      rx_rst_n <= !(state_nxt == ST_BOOT || state_nxt == ST_RXRST);
      busy     <= (state_nxt != ST_LINKED);
    end
  end
endmodule
